// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, opcode classification and the
// fixed vector addresses. IF/ID and decode reuse NOP_OP and the vectors.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        FETCH_OP  = 2'd1,
        FETCH_IMM = 2'd2,
        IRQ_VEC   = 2'd3
    } fetch_state_t;

    // Opcodes whose high nibble matches this carry a trailing immediate byte.
    localparam logic [3:0] TWO_BYTE_NIBBLE = 4'hC;

    localparam logic [7:0] NOP_OP         = 8'h00;
    localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
    localparam logic [7:0] IRQ_VEC_ADDR   = 8'h01;

    function automatic logic is_two_byte(input logic [7:0] opcode);
        return (opcode[7:4] == TWO_BYTE_NIBBLE);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and assembles one- and two-byte instructions for the IF/ID register.
// Optional feature macro: FETCH_IRQ_EN (interrupt vectoring and the ip flag).
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       irq,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [7:0] pc_plus_1,
    output logic [7:0] instr,
    output logic [7:0] immby,
    output logic       ip,
    output logic       instr_valid
);

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [7:0]   pc_r;
    logic [7:0]   pc_next_s;
    logic [7:0]   op_hold_r;
    logic [7:0]   op_hold_next_s;

    logic         redirect_s;
    logic         irq_take_s;
    logic         bubble_s;

    logic [7:0]   pres_instr_s;
    logic [7:0]   pres_immby_s;
    logic         pres_ip_s;
    logic         pres_valid_s;

`ifdef FETCH_IRQ_EN
    // An interrupt is only taken between instructions and never while held or redirected.
    assign irq_take_s = (state_r == FETCH_OP) && irq && !stall && !branch_taken;
`else
    logic unused_irq_s;
    assign unused_irq_s = irq;
    assign irq_take_s   = 1'b0;
`endif

    // Redirects are meaningless until the boot PC has been loaded.
    assign redirect_s = branch_taken && (state_r != BOOT);
    assign bubble_s   = redirect_s || irq_take_s;

    // Fetch address and the address following it for the current state.
    always_comb begin
        imem_addr = pc_r;
        pc_plus_1 = pc_r + 8'd1;
        case (state_r)
            BOOT: begin
                imem_addr = RESET_VEC_ADDR;
                pc_plus_1 = RESET_VEC_ADDR + 8'd1;
            end
            FETCH_OP, FETCH_IMM: begin
                imem_addr = pc_r;
                pc_plus_1 = pc_r + 8'd1;
            end
`ifdef FETCH_IRQ_EN
            IRQ_VEC: begin
                // pc still holds the interrupted fetch address: that is the return address.
                imem_addr = IRQ_VEC_ADDR;
                pc_plus_1 = pc_r;
            end
`endif
            default: begin
                imem_addr = RESET_VEC_ADDR;
                pc_plus_1 = RESET_VEC_ADDR + 8'd1;
            end
        endcase
    end

    // What the current state would present to IF/ID before any forced bubble.
    always_comb begin
        pres_instr_s = NOP_OP;
        pres_immby_s = 8'h00;
        pres_ip_s    = 1'b0;
        pres_valid_s = 1'b0;
        case (state_r)
            BOOT: begin
                pres_valid_s = 1'b0;
            end
            FETCH_OP: begin
                if (is_two_byte(imem_data)) begin
                    pres_valid_s = 1'b0;
                end else begin
                    pres_instr_s = imem_data;
                    pres_valid_s = 1'b1;
                end
            end
            FETCH_IMM: begin
                pres_instr_s = op_hold_r;
                pres_immby_s = imem_data;
                pres_valid_s = 1'b1;
            end
`ifdef FETCH_IRQ_EN
            IRQ_VEC: begin
                pres_ip_s    = 1'b1;
                pres_valid_s = 1'b1;
            end
`endif
            default: begin
                pres_valid_s = 1'b0;
            end
        endcase
    end

    assign instr       = bubble_s ? NOP_OP : pres_instr_s;
    assign immby       = bubble_s ? 8'h00  : pres_immby_s;
    assign ip          = bubble_s ? 1'b0   : pres_ip_s;
    assign instr_valid = bubble_s ? 1'b0   : pres_valid_s;

    // Next PC, state and held opcode: redirect beats stall, stall beats IRQ entry.
    always_comb begin
        state_next_s   = state_r;
        pc_next_s      = pc_r;
        op_hold_next_s = op_hold_r;
        if (redirect_s) begin
            pc_next_s      = branch_target;
            state_next_s   = FETCH_OP;
            op_hold_next_s = 8'h00;
        end else if (stall) begin
            state_next_s   = state_r;
            pc_next_s      = pc_r;
            op_hold_next_s = op_hold_r;
        end else if (irq_take_s) begin
            state_next_s = IRQ_VEC;
        end else begin
            case (state_r)
                BOOT: begin
                    pc_next_s    = imem_data;
                    state_next_s = FETCH_OP;
                end
                FETCH_OP: begin
                    pc_next_s = pc_r + 8'd1;
                    if (is_two_byte(imem_data)) begin
                        op_hold_next_s = imem_data;
                        state_next_s   = FETCH_IMM;
                    end else begin
                        state_next_s = FETCH_OP;
                    end
                end
                FETCH_IMM: begin
                    pc_next_s    = pc_r + 8'd1;
                    state_next_s = FETCH_OP;
                end
`ifdef FETCH_IRQ_EN
                IRQ_VEC: begin
                    pc_next_s    = imem_data;
                    state_next_s = FETCH_OP;
                end
`endif
                default: begin
                    state_next_s   = BOOT;
                    pc_next_s      = 8'h00;
                    op_hold_next_s = 8'h00;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset back to BOOT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= BOOT;
            pc_r      <= 8'h00;
            op_hold_r <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            op_hold_r <= op_hold_next_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural fetch model predicts every
// output each cycle, and a set of hand-computed literals pins that model.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       irq;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] pc_plus_1;
    logic [7:0] instr;
    logic [7:0] immby;
    logic       ip;
    logic       instr_valid;

    logic [7:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

`ifdef FETCH_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam int NV = 28;
    bit         v_rst   [NV];
    bit         v_stall [NV];
    bit         v_br    [NV];
    logic [7:0] v_tgt   [NV];
    bit         v_irq   [NV];

    // Model state: what the fetch unit is doing, in program terms.
    bit         m_booting;
    bit         m_vector_due;
    bit         m_imm_due;
    logic [7:0] m_pc;
    logic [7:0] m_opcode;

    logic [7:0] e_addr, e_p1, e_instr, e_imm;
    logic       e_ip, e_valid;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .irq          (irq),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .pc_plus_1    (pc_plus_1),
        .instr        (instr),
        .immby        (immby),
        .ip           (ip),
        .instr_valid  (instr_valid)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sv(input int i, input bit r, input bit s, input bit b,
                      input logic [7:0] t, input bit q);
        v_rst[i] = r; v_stall[i] = s; v_br[i] = b; v_tgt[i] = t; v_irq[i] = q;
    endtask

    task automatic model_reset();
        m_booting    = 1'b1;
        m_vector_due = 1'b0;
        m_imm_due    = 1'b0;
        m_pc         = 8'h00;
        m_opcode     = 8'h00;
    endtask

    function automatic bit two_byte(input logic [7:0] op);
        return op[7:4] == 4'hC;
    endfunction

    function automatic bit irq_accepted(input bit s, input bit b, input bit q);
        return IRQ_EN && q && !s && !b && !m_booting && !m_vector_due && !m_imm_due;
    endfunction

    // Expected outputs for the current model state and this cycle's inputs.
    task automatic model_expect(input bit s, input bit b, input bit q);
        logic [7:0] op;
        e_instr = 8'h00; e_imm = 8'h00; e_ip = 1'b0; e_valid = 1'b0;
        if (m_booting) begin
            e_addr = 8'h00;
            e_p1   = 8'h01;
        end else if (m_vector_due) begin
            e_addr = 8'h01; e_p1 = m_pc; e_ip = 1'b1; e_valid = 1'b1;
        end else if (m_imm_due) begin
            e_addr = m_pc; e_p1 = m_pc + 8'd1;
            e_instr = m_opcode; e_imm = mem[m_pc]; e_valid = 1'b1;
        end else begin
            e_addr = m_pc; e_p1 = m_pc + 8'd1;
            op = mem[m_pc];
            if (!two_byte(op)) begin
                e_instr = op; e_valid = 1'b1;
            end
        end
        if ((b && !m_booting) || irq_accepted(s, b, q)) begin
            e_instr = 8'h00; e_imm = 8'h00; e_ip = 1'b0; e_valid = 1'b0;
        end
    endtask

    // Advance the model by one clock.
    task automatic model_step(input bit s, input bit b, input logic [7:0] t, input bit q);
        logic [7:0] op;
        if (b && !m_booting) begin
            m_pc = t; m_imm_due = 1'b0; m_vector_due = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if (m_booting) begin
            m_pc = mem[8'h00]; m_booting = 1'b0;
        end else if (m_vector_due) begin
            m_pc = mem[8'h01]; m_vector_due = 1'b0;
        end else if (m_imm_due) begin
            m_pc = m_pc + 8'd1; m_imm_due = 1'b0;
        end else if (irq_accepted(s, b, q)) begin
            m_vector_due = 1'b1;
        end else begin
            op = mem[m_pc];
            m_pc = m_pc + 8'd1;
            if (two_byte(op)) begin
                m_imm_due = 1'b1; m_opcode = op;
            end
        end
    endtask

    // Hand-computed values for selected cycles, independent of the model.
    task automatic pin(input int i);
        case (i)
            0, 25: begin
                check("rst_addr", imem_addr, 8'h00); check("rst_p1", pc_plus_1, 8'h01);
                check("rst_instr", instr, 8'h00); check("rst_valid", {7'd0, instr_valid}, 8'h00);
            end
            1, 26: begin
                check("boot_addr", imem_addr, 8'h00); check("boot_valid", {7'd0, instr_valid}, 8'h00);
            end
            2, 27: begin
                check("first_addr", imem_addr, 8'h10); check("first_instr", instr, 8'h05);
                check("first_p1", pc_plus_1, 8'h11); check("first_valid", {7'd0, instr_valid}, 8'h01);
            end
            3: check("op_bubble", {7'd0, instr_valid}, 8'h00);
            4: begin
                check("two_instr", instr, 8'hC3); check("two_imm", immby, 8'h7A);
                check("two_p1", pc_plus_1, 8'h13); check("two_ip", {7'd0, ip}, 8'h00);
            end
            6: begin
                check("br_valid", {7'd0, instr_valid}, 8'h00); check("br_instr", instr, 8'h00);
                check("br_imm", immby, 8'h00);
            end
            7: check("br_addr", imem_addr, 8'h40);
            8, 10, 11: begin
                check("stall_addr", imem_addr, 8'h41); check("stall_instr", instr, 8'hC6);
                check("stall_imm", immby, 8'h9B); check("stall_p1", pc_plus_1, 8'h42);
            end
            12: begin
                check("rel_addr", imem_addr, 8'h42); check("rel_instr", instr, 8'h07);
            end
`ifdef FETCH_IRQ_EN
            16: begin
                check("irq_addr", imem_addr, 8'h22); check("irq_bubble", {7'd0, instr_valid}, 8'h00);
            end
            17: begin
                check("vec_addr", imem_addr, 8'h01); check("vec_ip", {7'd0, ip}, 8'h01);
                check("vec_p1", pc_plus_1, 8'h22); check("vec_valid", {7'd0, instr_valid}, 8'h01);
            end
            18: begin
                check("hnd_addr", imem_addr, 8'h80); check("hnd_instr", instr, 8'h2A);
            end
`else
            16: begin
                check("noirq_instr", instr, 8'h13); check("noirq_valid", {7'd0, instr_valid}, 8'h01);
            end
            17: begin
                check("noirq_addr", imem_addr, 8'h23); check("noirq_ip", {7'd0, ip}, 8'h00);
            end
`endif
            20: check("wrap_op_addr", imem_addr, 8'hFF);
            21: begin
                check("wrap_addr", imem_addr, 8'h00); check("wrap_instr", instr, 8'hCD);
                check("wrap_imm", immby, 8'h10); check("wrap_p1", pc_plus_1, 8'h01);
            end
            23: begin
                check("stall_irq_addr", imem_addr, 8'h02); check("stall_irq_ip", {7'd0, ip}, 8'h00);
                check("stall_irq_valid", {7'd0, instr_valid}, 8'h01);
            end
            24: check("held_addr", imem_addr, 8'h02);
            default: n_vec = n_vec;
        endcase
    endtask

    // Program, stimulus table and the per-cycle compare loop.
    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; irq = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h80;
        mem[8'h10] = 8'h05; mem[8'h11] = 8'hC3; mem[8'h12] = 8'h7A;
        mem[8'h13] = 8'hC4; mem[8'h14] = 8'h55;
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h12; mem[8'h22] = 8'h13;
        mem[8'h40] = 8'hC6; mem[8'h41] = 8'h9B; mem[8'h42] = 8'h07;
        mem[8'h80] = 8'h2A; mem[8'hFF] = 8'hCD;

        for (int i = 0; i < NV; i++) sv(i, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        sv(0,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sv(4,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        sv(6,  1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        sv(8,  1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        sv(9,  1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        sv(10, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        sv(13, 1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
        sv(16, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        sv(17, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        sv(19, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        sv(23, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        sv(25, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sv(26, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);

        model_reset();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst           = v_rst[i];
            stall         = v_stall[i];
            branch_taken  = v_br[i];
            branch_target = v_tgt[i];
            irq           = v_irq[i];
            if (!v_rst[i]) model_reset();
            #1;
            model_expect(v_stall[i], v_br[i], v_irq[i]);
            check("imem_addr", imem_addr, e_addr);
            check("pc_plus_1", pc_plus_1, e_p1);
            check("instr", instr, e_instr);
            check("immby", immby, e_imm);
            check("ip", {7'd0, ip}, {7'd0, e_ip});
            check("instr_valid", {7'd0, instr_valid}, {7'd0, e_valid});
            pin(i);
            if (v_rst[i]) model_step(v_stall[i], v_br[i], v_tgt[i], v_irq[i]);
            else model_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 8-bit pipelined processor, directly upstream of the IF/ID pipeline register. It owns the program counter and drives the instruction-memory address. It assembles one- and two-byte instructions (opcode plus immediate byte) and presents them, with PC+1 and the interrupt-pending flag, for capture by IF/ID. It also handles the boot vector, branch redirects, pipeline stalls and the interrupt vector.

## Interface
- RESET_VEC_ADDR, 8'h00: memory address holding the boot PC.
- IRQ_VEC_ADDR, 8'h01: memory address holding the interrupt handler PC.
- NOP_OP, 8'h00: opcode emitted for bubbles.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit hold; 1 freezes PC and state.
- branch_taken  in  1  redirect request from a later stage.
- branch_target  in  8  redirect PC.
- irq  in  1  level interrupt request.
- imem_addr  out  8  instruction-memory address (combinational read, same cycle).
- imem_data  in  8  instruction-memory read data.
- pc_plus_1  out  8  address following the presented instruction (or the return address in the IRQ cycle).
- instr  out  8  opcode presented to IF/ID.
- immby  out  8  immediate byte; 0 for one-byte instructions.
- ip  out  1  interrupt-pending flag to IF/ID.
- instr_valid  out  1  1 when instr/immby form a complete instruction or an IRQ marker.

## Operation
- Registers: pc[7:0], state, op_hold[7:0].
- States:
  - BOOT: imem_addr = RESET_VEC_ADDR; pc <= imem_data; next state FETCH_OP.
  - FETCH_OP: imem_addr = pc; pc <= pc+1.
    - If the opcode is two-byte, op_hold <= imem_data; next state FETCH_IMM; outputs a bubble.
    - Otherwise presents instr = imem_data, immby = 0, valid = 1.
  - FETCH_IMM: imem_addr = pc; pc <= pc+1; presents instr = op_hold, immby = imem_data, valid = 1; next state FETCH_OP.
  - IRQ_VEC: imem_addr = IRQ_VEC_ADDR; pc <= imem_data; presents instr = NOP_OP, ip = 1, pc_plus_1 = pc (the return address), valid = 1; next state FETCH_OP.
- Two-byte classification: opcode[7:4] == TWO_BYTE_NIBBLE, a package constant equal to 4'hC.
- Outputs other than in IRQ_VEC: pc_plus_1 = pc+1 of the current fetch address.
- Bubble: instr = NOP_OP, immby = 0, ip = 0, valid = 0.
- Priority, highest first: rst, branch_taken, stall, irq, normal sequencing.
- branch_taken, in any state except BOOT:
  - pc <= branch_target; state <= FETCH_OP; op_hold is discarded.
  - Outputs are forced to a bubble that cycle.
- stall: pc, state and op_hold hold their values; outputs keep being driven combinationally.
- irq is accepted only in FETCH_OP with stall = 0 and branch_taken = 0. An accepted irq replaces that cycle's fetch: pc is not incremented, outputs are a bubble, and the next state is IRQ_VEC. Because irq is only accepted in FETCH_OP, a two-byte instruction is never split by an interrupt.
- Arithmetic: pc+1 is modulo 256, so 8'hFF wraps to 8'h00. A two-byte opcode at 8'hFF takes its immediate from 8'h00.

## Timing
- Reset (asynchronous assert): state = BOOT, pc = 0, op_hold = 0. Outputs: instr = NOP_OP, immby = 0, ip = 0, instr_valid = 0, pc_plus_1 = 8'h01, imem_addr = RESET_VEC_ADDR.
- Reset deasserted mid-operation: restarts from BOOT; all in-flight state is lost.
- Latency:
  - First instruction is presented 1 cycle after BOOT.
  - One-byte instruction: presented in the same cycle it is read.
  - Two-byte instruction: presented 1 cycle after its opcode is read, with a bubble in the opcode cycle.
- IRQ: 1 bubble cycle, then 1 IRQ_VEC cycle; the handler's first opcode is fetched in the following cycle.
- Stall asserted in FETCH_IMM: waits, then presents the full instruction on the first unstalled cycle.

## Configuration
- FETCH_IRQ_EN defined: irq input, IRQ_VEC state and ip output are active as described above.
- FETCH_IRQ_EN undefined: irq is ignored, IRQ_VEC does not exist, ip is tied to 0. All other behaviour is identical.

## Structure
- Shared package contains:
  - the state enum (BOOT, FETCH_OP, FETCH_IMM, IRQ_VEC);
  - TWO_BYTE_NIBBLE;
  - NOP_OP and the default vector addresses, reused by IF/ID and decode.
- No sub-module is needed. The pc register with its next-pc mux may be split out as pc_unit if that is preferred; fetch_stage itself stays the single FSM.

## Test plan
- Boot: mem[0] = 8'h10, mem[0x10] = 8'h05 (one-byte), reset released → cycle 1 imem_addr = 8'h10, instr = 8'h05, pc_plus_1 = 8'h11, valid = 1.
- Two-byte: mem[0x10] = 8'hC3, mem[0x11] = 8'h7A → bubble, then instr = 8'hC3, immby = 8'h7A, pc_plus_1 = 8'h12.
- Branch during FETCH_IMM with branch_target = 8'h40 → bubble, op_hold discarded, next imem_addr = 8'h40.
- Stall for 3 cycles in FETCH_IMM → pc and outputs frozen; the full instruction is presented once after release.
- irq in FETCH_OP at pc = 8'h22 with mem[1] = 8'h80 (FETCH_IRQ_EN defined) → bubble, then ip = 1 with pc_plus_1 = 8'h22, then imem_addr = 8'h80.
- Wrap: two-byte opcode at 8'hFF → immediate read from 8'h00, pc_plus_1 = 8'h01.
